rd_engine: RTL and testbench

RD_ENGINE -- requirements
Module: rd_engine

---
 rtl/rd_engine_pkg.sv | 40 ++++
 rtl/rd_engine.sv | 201 ++++++++++++++++++++
 tb/tb_rd_engine.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rd_engine_pkg.sv
// Shared definitions for rd_engine: FSM states, lt_params field layout, fixed AXI AR field values.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package rd_engine_pkg;

  // Run-sequencing states; 3'd7 is unused and recovers to RD_IDLE
  typedef enum logic [2:0] {
    RD_IDLE     = 3'd0,
    RD_STARTED  = 3'd1,
    RD_TH_ADDR  = 3'd2,
    RD_TH_DATA  = 3'd3,
    RD_LAT_ADDR = 3'd4,
    RD_LAT_DATA = 3'd5,
    RD_END      = 3'd6
  } rd_state_e;

  // lt_params field offsets (LSB positions)
  localparam int LT_WGS_LSB    = 0;    // [31:0]   work_group_size, power of two
  localparam int LT_STRIDE_LSB = 32;   // [63:32]  stride in bytes
  localparam int LT_OPS_LSB    = 64;   // [127:64] number of read bursts
  localparam int LT_BURST_LSB  = 128;  // [159:128] burst size in bytes
  localparam int LT_ADDR_LSB   = 160;  // init_addr, ADDR_WIDTH bits
  localparam int LT_LAT_BIT    = 255;  // latency-mode select

  // Fixed AR channel field values
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
  localparam logic [3:0] AXI_QOS_NONE    = 4'b0000;
  localparam logic [3:0] AXI_REGION_NONE = 4'b0000;
  localparam logic [2:0] AXI_PROT_RD     = 3'b010;
  localparam logic [2:0] AXI_SIZE_32B    = 3'b101;
  localparam logic [2:0] AXI_SIZE_64B    = 3'b110;

  // Beat size code for the supported data widths (256 or 512 bits)
  function automatic logic [2:0] axi_size(input int dw);
    return (dw == 256) ? AXI_SIZE_32B : AXI_SIZE_64B;
  endfunction

endpackage

// File: rtl/rd_engine.sv
// AXI read traffic engine: issues num_mem_ops strided bursts, counts RLASTs/error beats, times the run.
// Latency: start -> RD_STARTED next cycle, first ARVALID one cycle later; end_of_exec one cycle after last RLAST.
// Backpressure: ARVALID/ARADDR held until ARREADY; RREADY tied high. Optional RD_LAT_MODE_EN builds latency mode.
module rd_engine
  import rd_engine_pkg::*;
#(
  parameter int ENGINE_ID   = 0,
  parameter int ADDR_WIDTH  = 33,
  parameter int DATA_WIDTH  = 256,
  parameter int PARAMS_BITS = 256,
  parameter int ID_WIDTH    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   end_of_exec,
  output logic [63:0]            lat_timer_sum,
  output logic [31:0]            rd_err_cnt,
  input  logic [PARAMS_BITS-1:0] lt_params,
  output logic                   m_axi_ARVALID,
  output logic [ADDR_WIDTH-1:0]  m_axi_ARADDR,
  output logic [ID_WIDTH-1:0]    m_axi_ARID,
  output logic [7:0]             m_axi_ARLEN,
  output logic [2:0]             m_axi_ARSIZE,
  output logic [1:0]             m_axi_ARBURST,
  output logic [1:0]             m_axi_ARLOCK,
  output logic [3:0]             m_axi_ARCACHE,
  output logic [3:0]             m_axi_ARQOS,
  output logic [3:0]             m_axi_ARREGION,
  output logic [2:0]             m_axi_ARPROT,
  input  logic                   m_axi_ARREADY,
  input  logic                   m_axi_RVALID,
  input  logic [DATA_WIDTH-1:0]  m_axi_RDATA,
  input  logic [1:0]             m_axi_RRESP,
  input  logic                   m_axi_RLAST,
  input  logic [ID_WIDTH-1:0]    m_axi_RID,
  output logic                   m_axi_RREADY
);

  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);

  rd_state_e              state;
  logic [PARAMS_BITS-1:0] params_q;
  logic [ADDR_WIDTH-1:0]  offset;
  logic [63:0]            op_cnt;
  logic [63:0]            rlast_cnt;

  // Decoded run parameters, always taken from the registered copy
  logic [31:0]           wgs;
  logic [31:0]           stride;
  logic [63:0]           num_ops;
  logic [31:0]           burst_bytes;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [31:0]           arlen_full;

  assign wgs         = params_q[LT_WGS_LSB +: 32];
  assign stride      = params_q[LT_STRIDE_LSB +: 32];
  assign num_ops     = params_q[LT_OPS_LSB +: 64];
  assign burst_bytes = params_q[LT_BURST_LSB +: 32];
  assign init_addr   = params_q[LT_ADDR_LSB +: ADDR_WIDTH];
  assign arlen_full  = (burst_bytes >> BEAT_SHIFT) - 32'd1;

  // Address of the request following the current handshake (offset wraps at ADDR_WIDTH)
  logic [ADDR_WIDTH-1:0] addr_mask;
  logic [ADDR_WIDTH-1:0] offset_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  assign addr_mask  = ADDR_WIDTH'(wgs) - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign offset_nxt = offset + ADDR_WIDTH'(stride);
  assign addr_nxt   = init_addr + (offset_nxt & addr_mask);

  logic        ar_hs;
  logic        r_beat;
  logic        rlast_hs;
  logic [63:0] rlast_nxt;
  logic        counting;

  assign ar_hs     = m_axi_ARVALID & m_axi_ARREADY;
  assign r_beat    = m_axi_RVALID & m_axi_RREADY;
  assign rlast_hs  = r_beat & m_axi_RLAST;
  assign rlast_nxt = rlast_cnt + {63'd0, rlast_hs};
  // Beats seen in RD_IDLE are stragglers from an abandoned run; RD_STARTED clears instead
  assign counting  = (state != RD_IDLE) && (state != RD_STARTED);

  // Fixed AR fields
  assign m_axi_ARID     = '0;
  assign m_axi_ARLEN    = arlen_full[7:0];
  assign m_axi_ARSIZE   = axi_size(DATA_WIDTH);
  assign m_axi_ARBURST  = AXI_BURST_INCR;
  assign m_axi_ARLOCK   = AXI_LOCK_NORMAL;
  assign m_axi_ARCACHE  = AXI_CACHE_NONE;
  assign m_axi_ARPROT   = AXI_PROT_RD;
  assign m_axi_ARQOS    = AXI_QOS_NONE;
  assign m_axi_ARREGION = AXI_REGION_NONE;
  assign m_axi_RREADY   = 1'b1;

  // Data payload, ID and spare parameter bits are deliberately not consumed
  logic unused_ok;
  assign unused_ok = ^{m_axi_RDATA, m_axi_RID, params_q, arlen_full, 32'(ENGINE_ID)};

  // Run sequencer: parameter capture, AR issue and completion tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RD_IDLE;
      params_q      <= '0;
      m_axi_ARVALID <= 1'b0;
      m_axi_ARADDR  <= '0;
      offset        <= '0;
      op_cnt        <= '0;
      end_of_exec   <= 1'b0;
    end else begin
      end_of_exec <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (start) begin
            params_q <= lt_params;
            state    <= RD_STARTED;
          end
        end
        RD_STARTED: begin
          offset       <= '0;
          op_cnt       <= '0;
          m_axi_ARADDR <= init_addr;
          if (num_ops == 64'd0) begin
            state <= RD_END;
`ifdef RD_LAT_MODE_EN
          end else if (params_q[LT_LAT_BIT]) begin
            state         <= RD_LAT_ADDR;
            m_axi_ARVALID <= 1'b1;
`endif
          end else begin
            state         <= RD_TH_ADDR;
            m_axi_ARVALID <= 1'b1;
          end
        end
        RD_TH_ADDR: begin
          if (ar_hs) begin
            offset       <= offset_nxt;
            m_axi_ARADDR <= addr_nxt;
            op_cnt       <= op_cnt + 64'd1;
            if (op_cnt + 64'd1 == num_ops) begin
              m_axi_ARVALID <= 1'b0;
              state         <= (rlast_nxt == num_ops) ? RD_END : RD_TH_DATA;
            end
          end
        end
        RD_TH_DATA: begin
          if (rlast_nxt == num_ops) state <= RD_END;
        end
`ifdef RD_LAT_MODE_EN
        RD_LAT_ADDR: begin
          if (ar_hs) begin
            offset        <= offset_nxt;
            m_axi_ARADDR  <= addr_nxt;
            op_cnt        <= op_cnt + 64'd1;
            m_axi_ARVALID <= 1'b0;
            state         <= RD_LAT_DATA;
          end
        end
        RD_LAT_DATA: begin
          if (rlast_hs) begin
            if (op_cnt == num_ops) begin
              state <= RD_END;
            end else begin
              state         <= RD_LAT_ADDR;
              m_axi_ARVALID <= 1'b1;
            end
          end
        end
`endif
        RD_END: begin
          end_of_exec <= 1'b1;
          state       <= RD_IDLE;
        end
        default: begin
          state         <= RD_IDLE;
          m_axi_ARVALID <= 1'b0;
        end
      endcase
    end
  end

  // Run statistics: RLAST count, cycle timer and saturating error-beat count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rlast_cnt     <= '0;
      lat_timer_sum <= '0;
      rd_err_cnt    <= '0;
    end else if (state == RD_STARTED) begin
      rlast_cnt     <= '0;
      lat_timer_sum <= '0;
      rd_err_cnt    <= '0;
    end else if (counting) begin
      lat_timer_sum <= lat_timer_sum + 64'd1;
      rlast_cnt     <= rlast_nxt;
      if (r_beat && (m_axi_RRESP != 2'b00) && (rd_err_cnt != 32'hFFFF_FFFF))
        rd_err_cnt <= rd_err_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_rd_engine.sv
// Self-checking bench for rd_engine: AXI read slave with in-order bursts and configurable latency,
// directed and randomized runs compared against an arithmetic model of addresses, lengths and counts.
// Build with or without RD_LAT_MODE_EN; the latency-mode expectations follow the macro.
module tb_rd_engine;

  localparam int AW = 33;
  localparam int DW = 256;
  localparam int PB = 256;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          end_of_exec;
  logic [63:0]   lat_timer_sum;
  logic [31:0]   rd_err_cnt;
  logic [PB-1:0] lt_params;
  logic          m_axi_ARVALID;
  logic [AW-1:0] m_axi_ARADDR;
  logic [IW-1:0] m_axi_ARID;
  logic [7:0]    m_axi_ARLEN;
  logic [2:0]    m_axi_ARSIZE;
  logic [1:0]    m_axi_ARBURST;
  logic [1:0]    m_axi_ARLOCK;
  logic [3:0]    m_axi_ARCACHE;
  logic [3:0]    m_axi_ARQOS;
  logic [3:0]    m_axi_ARREGION;
  logic [2:0]    m_axi_ARPROT;
  logic          m_axi_ARREADY;
  logic          m_axi_RVALID;
  logic [DW-1:0] m_axi_RDATA;
  logic [1:0]    m_axi_RRESP;
  logic          m_axi_RLAST;
  logic [IW-1:0] m_axi_RID;
  logic          m_axi_RREADY;

  always #5 clk = ~clk;

  rd_engine dut (
    .clk(clk), .rst(rst), .start(start), .end_of_exec(end_of_exec),
    .lat_timer_sum(lat_timer_sum), .rd_err_cnt(rd_err_cnt), .lt_params(lt_params),
    .m_axi_ARVALID(m_axi_ARVALID), .m_axi_ARADDR(m_axi_ARADDR), .m_axi_ARID(m_axi_ARID),
    .m_axi_ARLEN(m_axi_ARLEN), .m_axi_ARSIZE(m_axi_ARSIZE), .m_axi_ARBURST(m_axi_ARBURST),
    .m_axi_ARLOCK(m_axi_ARLOCK), .m_axi_ARCACHE(m_axi_ARCACHE), .m_axi_ARQOS(m_axi_ARQOS),
    .m_axi_ARREGION(m_axi_ARREGION), .m_axi_ARPROT(m_axi_ARPROT), .m_axi_ARREADY(m_axi_ARREADY),
    .m_axi_RVALID(m_axi_RVALID), .m_axi_RDATA(m_axi_RDATA), .m_axi_RRESP(m_axi_RRESP),
    .m_axi_RLAST(m_axi_RLAST), .m_axi_RID(m_axi_RID), .m_axi_RREADY(m_axi_RREADY)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave model state
  typedef struct { longint unsigned due; int len; } ar_t;
  ar_t              pend[$];
  longint unsigned  cyc = 0;
  int               beat_idx = 0;
  logic [63:0]      ar_addr_q[$];
  logic [7:0]       ar_len_q[$];
  int               max_out = 0;
  int               err_seen = 0;
  int               lat_cfg = 10;
  int               ar_rand = 0;
  int               r_stall = 0;
  int               err_pct = 0;

  localparam longint unsigned MASK_A = (64'd1 << AW) - 64'd1;

  function automatic logic [PB-1:0] pack(input longint unsigned wgs, stride, ops, burst, init,
                                         input bit lat);
    logic [PB-1:0] p;
    p = '0;
    p[31:0]     = wgs[31:0];
    p[63:32]    = stride[31:0];
    p[127:64]   = ops;
    p[159:128]  = burst[31:0];
    p[160 +: AW] = init[AW-1:0];
    p[255]      = lat;
    return p;
  endfunction

  // One run: launch, wait for end_of_exec, compare against the address/length/count model
  task automatic run(input string tag, input longint unsigned wgs, stride, ops, burst, init,
                     input bit lat, input int lat_c, ar_r, stall, errp, input bit mid_start);
    int n;
    int valid_seen;
    longint unsigned off;
    longint unsigned exp_addr;
    logic [63:0] held;
    lat_cfg = lat_c; ar_rand = ar_r; r_stall = stall; err_pct = errp;
    ar_addr_q.delete(); ar_len_q.delete(); max_out = 0; err_seen = 0;
    @(negedge clk);
    lt_params = pack(wgs, stride, ops, burst, init, lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; valid_seen = 0;
    while (!end_of_exec && n < 2000) begin
      if (m_axi_ARVALID) valid_seen++;
      start = (mid_start && n == 3);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, ".done"}, 64'(end_of_exec), 64'd1);
    chk({tag, ".lat_timer"}, lat_timer_sum, 64'(n - 1));
    if (ops == 0) begin
      chk({tag, ".eoe_delay"}, 64'(n), 64'd2);
      chk({tag, ".no_arvalid"}, 64'(valid_seen), 64'd0);
    end
    chk({tag, ".n_ar"}, 64'(ar_addr_q.size()), ops);
    for (int i = 0; i < ar_addr_q.size() && longint'(i) < longint'(ops); i++) begin
      off = (longint'(i) * stride) & MASK_A;
      exp_addr = (init + (off & (wgs - 64'd1))) & MASK_A;
      chk($sformatf("%s.addr%0d", tag, i), ar_addr_q[i], exp_addr);
      chk($sformatf("%s.len%0d", tag, i), 64'(ar_len_q[i]), ((burst / 32) - 64'd1) & 64'hFF);
    end
    chk({tag, ".err_cnt"}, 64'(rd_err_cnt), 64'(err_seen));
    held = lat_timer_sum;
    @(negedge clk);
    chk({tag, ".eoe_pulse"}, 64'(end_of_exec), 64'd0);
    repeat (4) @(negedge clk);
    chk({tag, ".idle_hold"}, {63'd0, m_axi_ARVALID} + 64'(ar_addr_q.size()), ops);
    chk({tag, ".timer_hold"}, lat_timer_sum, held);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit lat_built;
    longint unsigned r_ops;
    rst = 1'b1; start = 1'b0; lt_params = '0;
    m_axi_ARREADY = 1'b0; m_axi_RVALID = 1'b0; m_axi_RDATA = '0;
    m_axi_RRESP = 2'b00; m_axi_RLAST = 1'b0; m_axi_RID = '0;
`ifdef RD_LAT_MODE_EN
    lat_built = 1'b1;
`else
    lat_built = 1'b0;
`endif

    // AXI read slave: in-order bursts, first beat lat_cfg cycles after the AR handshake
    fork
      forever begin
        @(posedge clk);
        cyc++;
        if (m_axi_RVALID && m_axi_RREADY) begin
          if (!rst && m_axi_RRESP != 2'b00) err_seen++;
          if (m_axi_RLAST) begin
            pend.delete(0);
            beat_idx = 0;
          end else begin
            beat_idx++;
          end
        end
        if (!rst && m_axi_ARVALID && m_axi_ARREADY) begin
          pend.push_back('{due: cyc + longint'(lat_cfg), len: int'(m_axi_ARLEN)});
          ar_addr_q.push_back(64'(m_axi_ARADDR));
          ar_len_q.push_back(m_axi_ARLEN);
          if (pend.size() > max_out) max_out = pend.size();
        end
        @(negedge clk);
        m_axi_ARREADY = (ar_rand != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (pend.size() != 0 && cyc >= pend[0].due &&
            !(r_stall != 0 && $urandom_range(0, 3) == 0)) begin
          m_axi_RVALID = 1'b1;
          m_axi_RLAST  = (beat_idx == pend[0].len);
          m_axi_RRESP  = (int'($urandom_range(0, 99)) < err_pct) ? 2'b10 : 2'b00;
          m_axi_RDATA  = {8{$urandom}};
        end else begin
          m_axi_RVALID = 1'b0;
          m_axi_RLAST  = 1'b0;
          m_axi_RRESP  = 2'b00;
        end
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.arvalid", 64'(m_axi_ARVALID), 64'd0);
    chk("rst.eoe", 64'(end_of_exec), 64'd0);
    chk("rst.timer", lat_timer_sum, 64'd0);
    chk("rst.err", 64'(rd_err_cnt), 64'd0);
    chk("rst.araddr", 64'(m_axi_ARADDR), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("fix.rready", 64'(m_axi_RREADY), 64'd1);
    chk("fix.arid", 64'(m_axi_ARID), 64'd0);
    chk("fix.arsize", 64'(m_axi_ARSIZE), 64'd5);
    chk("fix.arburst", 64'(m_axi_ARBURST), 64'd1);
    chk("fix.arprot", 64'(m_axi_ARPROT), 64'd2);
    chk("fix.misc", {52'd0, m_axi_ARLOCK, m_axi_ARCACHE, m_axi_ARQOS, m_axi_ARREGION}, 64'd0);

    // Throughput with a stray start mid-run, wrap, zero ops, error beats
    run("thru", 4096, 64, 8, 64, 0, 1'b0, 10, 0, 0, 0, 1'b1);
    chk("thru.addr7", ar_addr_q.size() == 8 ? ar_addr_q[7] : 64'hDEAD, 64'h1C0);
    run("wrap", 256, 128, 4, 64, 64'h1000, 1'b0, 3, 0, 0, 0, 1'b0);
    run("zero", 4096, 64, 0, 64, 0, 1'b0, 3, 0, 0, 0, 1'b0);
    run("err", 4096, 32, 5, 32, 64'h2000, 1'b0, 5, 0, 0, 100, 1'b0);
    chk("err.count5", 64'(rd_err_cnt), 64'd5);

    // Latency mode request (ignored when latency mode is not built)
    run("lat", 4096, 64, 3, 64, 64'h100, 1'b1, 20, 0, 0, 0, 1'b0);
    if (lat_built) begin
      chk("lat.outstanding", 64'(max_out <= 1), 64'd1);
      chk("lat.timer_range", 64'(lat_timer_sum >= 64'd66 && lat_timer_sum <= 64'd72), 64'd1);
    end else begin
      chk("lat.ignored_outstanding", 64'(max_out), 64'd3);
    end

    // Reset after the third AR, then late beats must not disturb the counters
    lat_cfg = 10; ar_rand = 0; r_stall = 0; err_pct = 100;
    ar_addr_q.delete(); ar_len_q.delete();
    @(negedge clk);
    lt_params = pack(4096, 64, 8, 64, 0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (ar_addr_q.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid.third_ar", 64'(ar_addr_q.size()), 64'd3);
    chk("mid.arvalid_pre", 64'(m_axi_ARVALID), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid.arvalid", 64'(m_axi_ARVALID), 64'd0);
    chk("mid.timer", lat_timer_sum, 64'd0);
    chk("mid.err", 64'(rd_err_cnt), 64'd0);
    chk("mid.araddr", 64'(m_axi_ARADDR), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid.late_err", 64'(rd_err_cnt), 64'd0);
    chk("mid.late_timer", lat_timer_sum, 64'd0);
    chk("mid.late_arvalid", 64'(m_axi_ARVALID), 64'd0);
    chk("mid.drained", 64'(pend.size()), 64'd0);
    run("after_rst", 4096, 64, 8, 64, 0, 1'b0, 10, 0, 0, 0, 1'b0);

    // Randomized runs: random ARREADY, R gaps, error beats, geometry
    for (int k = 0; k < 4; k++) begin
      r_ops = longint'($urandom_range(1, 10));
      run($sformatf("rnd%0d", k), 64'd1 << $urandom_range(5, 16), 64'($urandom),
          r_ops, 64'(32 * $urandom_range(1, 4)),
          {31'd0, 1'($urandom_range(0, 1)), $urandom},
          1'b0, int'($urandom_range(0, 12)), 1, 1, 30, r_ops >= 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
